// File: rtl/divider_seq.sv
// Iterative restoring divider: one trial subtraction per cycle over BITS cycles.
// Optional two's-complement support is enabled by defining DIVIDER_SIGNED_EN.
module divider_seq #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
`ifdef DIVIDER_SIGNED_EN
    input  logic            sign_mode,
`endif
    input  logic [BITS-1:0] dividend,
    input  logic [BITS-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] quotient,
    output logic [BITS-1:0] remainder,
    output logic            div_zero
);

    localparam int CW = $clog2(BITS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [BITS-1:0] rem_r;
    logic [BITS-1:0] quo_r;
    logic [BITS-1:0] dvsr;
    logic            neg_q;
    logic            neg_r;

    logic            dvd_neg;
    logic            dvs_neg;
    logic [BITS-1:0] dvd_mag;
    logic [BITS-1:0] dvs_mag;

`ifdef DIVIDER_SIGNED_EN
    // Operands are reduced to magnitudes; signs are re-applied at the final load.
    assign dvd_neg = sign_mode & dividend[BITS-1];
    assign dvs_neg = sign_mode & divisor[BITS-1];
`else
    assign dvd_neg = 1'b0;
    assign dvs_neg = 1'b0;
`endif
    assign dvd_mag = dvd_neg ? ('0 - dividend) : dividend;
    assign dvs_mag = dvs_neg ? ('0 - divisor) : divisor;

    logic [BITS:0]   trial;
    logic [BITS:0]   subtrahend;
    logic [BITS:0]   diff;
    logic            borrow;
    logic [BITS-1:0] r_next;
    logic [BITS-1:0] q_next;
    logic [BITS-1:0] q_final;
    logic [BITS-1:0] r_final;

    // Ripple-borrow subtractor, BITS+1 wide, borrow-in tied low.
    always_comb begin
        trial      = {rem_r, quo_r[BITS-1]};
        subtrahend = {1'b0, dvsr};
        diff       = '0;
        borrow     = 1'b0;
        for (int i = 0; i <= BITS; i++) begin
            diff[i] = trial[i] ^ subtrahend[i] ^ borrow;
            borrow  = (~trial[i] & subtrahend[i]) | (~(trial[i] ^ subtrahend[i]) & borrow);
        end
    end

    assign r_next  = borrow ? trial[BITS-1:0] : diff[BITS-1:0];
    assign q_next  = {quo_r[BITS-2:0], ~borrow};
    assign q_final = neg_q ? ('0 - q_next) : q_next;
    assign r_final = neg_r ? ('0 - r_next) : r_next;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it sits inside the clocked branch, not the sensitivity list.
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            dvsr      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                            state     <= DONE;
                        end else begin
                            rem_r <= '0;
                            quo_r <= dvd_mag;
                            dvsr  <= dvs_mag;
                            neg_q <= dvd_neg ^ dvs_neg;
                            neg_r <= dvd_neg;
                            cnt   <= CW'(BITS - 1);
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_r <= r_next;
                    quo_r <= q_next;
                    if (cnt == '0) begin
                        quotient  <= q_final;
                        remainder <= r_final;
                        div_zero  <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
